// File: rtl/quad_decoder_array.sv
// quad_decoder_array: multi-channel quadrature decoder with glitch filter, detent FSM and wrapping position counter; ENC_VELOCITY_EN adds a steps-per-window velocity measurement
module quad_decoder_array #(
  parameter int NUM_CH   = 2,
  parameter int CNT_W    = 5,
  parameter int MODULUS  = 20,
  parameter int FILT_LEN = 4,
  parameter int VEL_WIN  = 100000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       enc_a,
  input  logic [NUM_CH-1:0]       enc_b,
  input  logic [NUM_CH-1:0]       clr,
  output logic [NUM_CH*CNT_W-1:0] count,
  output logic [NUM_CH-1:0]       step_up,
  output logic [NUM_CH-1:0]       step_dn,
  output logic [NUM_CH-1:0]       dir,
  output logic [NUM_CH*8-1:0]     vel,
  output logic                    vel_valid
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_R1   = 3'd1;
  localparam logic [2:0] S_R2   = 3'd2;
  localparam logic [2:0] S_R3   = 3'd3;
  localparam logic [2:0] S_L1   = 3'd4;
  localparam logic [2:0] S_L2   = 3'd5;
  localparam logic [2:0] S_L3   = 3'd6;
  localparam logic [CNT_W-1:0] TOP = (MODULUS == 0) ? {CNT_W{1'b1}} : CNT_W'(MODULUS - 1);

  if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
    $error("NUM_CH must be 1..8");
  end
  if (FILT_LEN < 1 || FILT_LEN > 16) begin : g_bad_filt_len
    $error("FILT_LEN must be 1..16");
  end
  if (MODULUS < 0 || MODULUS > (1 << CNT_W)) begin : g_bad_modulus
    $error("MODULUS must be 0 or at most 2^CNT_W");
  end
  if (VEL_WIN < 2) begin : g_bad_vel_win
    $error("VEL_WIN must be at least 2");
  end

`ifdef ENC_VELOCITY_EN
  localparam int WIN_W = $clog2(VEL_WIN);
  logic [WIN_W-1:0] win_q;
  logic             win_end;
  logic             vv_q;
  assign win_end   = win_q == WIN_W'(VEL_WIN - 1);
  assign vel_valid = vv_q;
  // free-running window counter; vel_valid follows the last window cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      win_q <= '0;
      vv_q  <= 1'b0;
    end else begin
      win_q <= win_end ? '0 : win_q + WIN_W'(1);
      vv_q  <= win_end;
    end
`else
  assign vel       = '0;
  assign vel_valid = 1'b0;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [1:0]       s1_q, s2_q, f_q;
    logic [4:0]       run_q [2];
    logic [2:0]       st_q, st_d;
    logic             up_q, up_d, dn_q, dn_d, dir_q, dir_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             a, b;
    assign a = f_q[0];
    assign b = f_q[1];
    // two-flop synchronizer then per-bit stability filter (bit 0 = A, bit 1 = B)
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        s1_q     <= '1;
        s2_q     <= '1;
        f_q      <= '1;
        run_q[0] <= '0;
        run_q[1] <= '0;
      end else begin
        s1_q <= {enc_b[i], enc_a[i]};
        s2_q <= s1_q;
        for (int k = 0; k < 2; k++)
          if (s2_q[k] == f_q[k]) run_q[k] <= '0;
          else if (run_q[k] == 5'(FILT_LEN - 1)) begin
            f_q[k]   <= s2_q[k];
            run_q[k] <= '0;
          end else run_q[k] <= run_q[k] + 5'd1;
      end
    // detent FSM: a step is only produced on re-entering IDLE from R3 or L3
    always_comb begin
      st_d = S_IDLE;
      up_d = 1'b0;
      dn_d = 1'b0;
      case (st_q)
        S_IDLE: st_d = !b ? S_R1 : !a ? S_L1 : S_IDLE;
        S_R1:   st_d = b ? S_IDLE : !a ? S_R2 : S_R1;
        S_R2:   st_d = a ? S_R1 : b ? S_R3 : S_R2;
        S_R3: begin
          st_d = !b ? S_R2 : a ? S_IDLE : S_R3;
          up_d = b & a;
        end
        S_L1:   st_d = a ? S_IDLE : !b ? S_L2 : S_L1;
        S_L2:   st_d = b ? S_L1 : a ? S_L3 : S_L2;
        S_L3: begin
          st_d = !a ? S_L2 : b ? S_IDLE : S_L3;
          dn_d = a & b;
        end
        default: st_d = S_IDLE;
      endcase
    end
    // clear wins over a simultaneous step; direction still follows the step
    always_comb begin
      cnt_d = clr[i] ? '0
            : up_d   ? (cnt_q == TOP ? '0 : cnt_q + CNT_W'(1))
            : dn_d   ? (cnt_q == '0 ? TOP : cnt_q - CNT_W'(1))
            : cnt_q;
      dir_d = up_d ? 1'b1 : dn_d ? 1'b0 : dir_q;
    end
    // FSM state, step pulses, position and direction registers
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        st_q  <= S_IDLE;
        up_q  <= 1'b0;
        dn_q  <= 1'b0;
        dir_q <= 1'b0;
        cnt_q <= '0;
      end else begin
        st_q  <= st_d;
        up_q  <= up_d;
        dn_q  <= dn_d;
        dir_q <= dir_d;
        cnt_q <= cnt_d;
      end
    assign count[i*CNT_W +: CNT_W] = cnt_q;
    assign step_up[i] = up_q;
    assign step_dn[i] = dn_q;
    assign dir[i]     = dir_q;
`ifdef ENC_VELOCITY_EN
    logic [7:0] tal_q, vel_q;
    logic       stp;
    assign stp = up_q | dn_q;
    // saturating step tally; a step in the last window cycle opens the next tally
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        tal_q <= '0;
        vel_q <= '0;
      end else if (win_end) begin
        vel_q <= tal_q;
        tal_q <= {7'd0, stp};
      end else if (stp && tal_q != 8'hFF) tal_q <= tal_q + 8'd1;
    assign vel[i*8 +: 8] = vel_q;
`endif
  end

endmodule

// File: tb/tb_quad_decoder_array.sv
// tb_quad_decoder_array: scoreboard bench for quad_decoder_array; velocity checks active when ENC_VELOCITY_EN is defined
module tb_quad_decoder_array;
  localparam int NCH = 2;
  localparam int CW  = 5;
  localparam int MOD = 20;
  localparam int FL  = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NCH-1:0]   enc_a = '1, enc_b = '1, clr = '0;
  logic [NCH*CW-1:0] count;
  logic [NCH-1:0]   step_up, step_dn, dir;
  logic [NCH*8-1:0] vel;
  logic             vel_valid;

  typedef struct {logic up; logic [CW-1:0] cnt; logic dir;} exp_t;
  exp_t sb [NCH][$];
  exp_t e;
  int   total = 0, bad = 0, vv_seen = 0;
  int   mcnt [NCH] = '{0, 0};

  quad_decoder_array #(.NUM_CH(NCH), .CNT_W(CW), .MODULUS(MOD), .FILT_LEN(FL), .VEL_WIN(1000)) dut (
    .clk(clk), .rst_n(rst_n), .enc_a(enc_a), .enc_b(enc_b), .clr(clr),
    .count(count), .step_up(step_up), .step_dn(step_dn), .dir(dir),
    .vel(vel), .vel_valid(vel_valid)
  );

  always #5 clk = ~clk;

  // scoreboard: every step pulse must match the oldest expected step of its channel
  always @(negedge clk) begin
    if (vel_valid) vv_seen++;
    for (int c = 0; c < NCH; c++)
      if (step_up[c] || step_dn[c]) begin
        total++;
        if (sb[c].size() == 0) begin
          bad++;
          $display("FAIL unexpected_step ch%0d got up=%0b dn=%0b count=%0d want no step", c, step_up[c], step_dn[c], count[c*CW +: CW]);
        end else begin
          e = sb[c].pop_front();
          if (step_up[c] !== e.up || step_dn[c] !== !e.up || count[c*CW +: CW] !== e.cnt || dir[c] !== e.dir) begin
            bad++;
            $display("FAIL step_ch%0d got up=%0b dn=%0b count=%0d dir=%0b want up=%0b dn=%0b count=%0d dir=%0b",
                     c, step_up[c], step_dn[c], count[c*CW +: CW], dir[c], e.up, !e.up, e.cnt, e.dir);
          end
        end
      end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_step(input int ch, input bit up);
    mcnt[ch] = up ? (mcnt[ch] + 1) % MOD : (mcnt[ch] + MOD - 1) % MOD;
    sb[ch].push_back('{up, CW'(mcnt[ch]), up});
  endtask

  task automatic cw(input int ch);
    enc_b[ch] = 1'b0; cyc(10);
    enc_a[ch] = 1'b0; cyc(10);
    enc_b[ch] = 1'b1; cyc(10);
    push_step(ch, 1'b1);
    enc_a[ch] = 1'b1; cyc(10);
  endtask

  task automatic ccw(input int ch);
    enc_a[ch] = 1'b0; cyc(10);
    enc_b[ch] = 1'b0; cyc(10);
    enc_a[ch] = 1'b1; cyc(10);
    push_step(ch, 1'b0);
    enc_b[ch] = 1'b1; cyc(10);
  endtask

  task automatic test_reset;
    cyc(3);
    total++; if (count !== '0) begin bad++; $display("FAIL rst_count got=%0h want=0", count); end
    total++; if ((step_up | step_dn) !== '0) begin bad++; $display("FAIL rst_steps got=%0b want=0", step_up | step_dn); end
    total++; if (dir !== '0) begin bad++; $display("FAIL rst_dir got=%0b want=0", dir); end
    total++; if (vel !== '0 || vel_valid !== 1'b0) begin bad++; $display("FAIL rst_vel got=%0h/%0b want=0/0", vel, vel_valid); end
    rst_n = 1'b1; cyc(5);
    enc_b[0] = 1'b0; cyc(10);
    enc_a[0] = 1'b0; cyc(10);
    enc_b[0] = 1'b1; cyc(10);
    rst_n = 1'b0; cyc(2);
    enc_a = '1; enc_b = '1; cyc(2);
    rst_n = 1'b1; cyc(30);
    total++; if (count !== '0) begin bad++; $display("FAIL rst_midrot_count got=%0h want=0", count); end
  endtask

  task automatic test_cw;
    cw(0); cyc(5);
    total++; if (count[0 +: CW] !== CW'(1)) begin bad++; $display("FAIL cw_count0 got=%0d want=1", count[0 +: CW]); end
    total++; if (dir[0] !== 1'b1) begin bad++; $display("FAIL cw_dir0 got=%0b want=1", dir[0]); end
    total++; if (count[CW +: CW] !== '0) begin bad++; $display("FAIL cw_count1 got=%0d want=0", count[CW +: CW]); end
    total++; if (sb[0].size() != 0) begin bad++; $display("FAIL cw_missing_step got=%0d pending want=0", sb[0].size()); end
  endtask

  task automatic test_ccw_wrap;
    ccw(0); ccw(0); cyc(5);
    total++; if (count[0 +: CW] !== CW'(MOD - 1)) begin bad++; $display("FAIL ccw_wrap_count0 got=%0d want=%0d", count[0 +: CW], MOD - 1); end
    total++; if (dir[0] !== 1'b0) begin bad++; $display("FAIL ccw_dir0 got=%0b want=0", dir[0]); end
    cw(0); cyc(5);
    total++; if (count[0 +: CW] !== '0) begin bad++; $display("FAIL cw_wrap_count0 got=%0d want=0", count[0 +: CW]); end
    total++; if (sb[0].size() != 0) begin bad++; $display("FAIL ccw_missing_step got=%0d pending want=0", sb[0].size()); end
  endtask

  task automatic test_glitch;
    enc_b[0] = 1'b0; cyc(2); enc_b[0] = 1'b1; cyc(20);
    total++; if (count[0 +: CW] !== CW'(mcnt[0])) begin bad++; $display("FAIL glitch_b_count0 got=%0d want=%0d", count[0 +: CW], mcnt[0]); end
    enc_b[0] = 1'b0; cyc(10);
    enc_a[0] = 1'b0; cyc(10);
    enc_b[0] = 1'b1; cyc(10);
    enc_a[0] = 1'b1; cyc(FL - 1); enc_a[0] = 1'b0; cyc(20);
    total++; if (count[0 +: CW] !== CW'(mcnt[0])) begin bad++; $display("FAIL short_pulse_count0 got=%0d want=%0d", count[0 +: CW], mcnt[0]); end
    push_step(0, 1'b1);
    enc_a[0] = 1'b1; cyc(FL); enc_a[0] = 1'b0; cyc(20);
    enc_a[0] = 1'b1; cyc(20);
    total++; if (count[0 +: CW] !== CW'(mcnt[0])) begin bad++; $display("FAIL min_pulse_count0 got=%0d want=%0d", count[0 +: CW], mcnt[0]); end
    total++; if (sb[0].size() != 0) begin bad++; $display("FAIL min_pulse_missing_step got=%0d pending want=0", sb[0].size()); end
  endtask

  task automatic test_latency;
    int n;
    enc_b[0] = 1'b0; cyc(10);
    enc_a[0] = 1'b0; cyc(10);
    enc_b[0] = 1'b1; cyc(10);
    push_step(0, 1'b1);
    enc_a[0] = 1'b1;
    n = 0;
    while (!step_up[0] && n < 50) begin @(negedge clk); n++; end
    total++; if (n != FL + 3) begin bad++; $display("FAIL step_latency got=%0d want=%0d", n, FL + 3); end
    cyc(10);
  endtask

  task automatic test_reversal;
    enc_b[0] = 1'b0; cyc(10);
    enc_a[0] = 1'b0; cyc(10);
    enc_a[0] = 1'b1; cyc(10);
    enc_b[0] = 1'b1; cyc(10);
    total++; if (count[0 +: CW] !== CW'(mcnt[0])) begin bad++; $display("FAIL reversal_count0 got=%0d want=%0d", count[0 +: CW], mcnt[0]); end
    cw(0); cyc(5);
    total++; if (sb[0].size() != 0) begin bad++; $display("FAIL reversal_fsm_not_idle got=%0d pending want=0", sb[0].size()); end
  endtask

  task automatic test_back_to_back_clr;
    for (int k = 0; k < 5; k++) cw(1);
    cyc(5);
    total++; if (count[CW +: CW] !== CW'(5)) begin bad++; $display("FAIL ch1_setup got=%0d want=5", count[CW +: CW]); end
    enc_b[0] = 1'b0; enc_a[1] = 1'b0; cyc(10);
    enc_a[0] = 1'b0; enc_b[1] = 1'b0; cyc(10);
    enc_b[0] = 1'b1; enc_a[1] = 1'b1; cyc(10);
    mcnt[0] = 0;
    sb[0].push_back('{1'b1, CW'(0), 1'b1});
    push_step(1, 1'b0);
    enc_a[0] = 1'b1; enc_b[1] = 1'b1; cyc(FL + 2);
    clr[0] = 1'b1; cyc(1); clr[0] = 1'b0; cyc(10);
    total++; if (count[0 +: CW] !== '0) begin bad++; $display("FAIL clr_step_count0 got=%0d want=0", count[0 +: CW]); end
    total++; if (count[CW +: CW] !== CW'(4)) begin bad++; $display("FAIL simul_dn_count1 got=%0d want=4", count[CW +: CW]); end
    total++; if (sb[0].size() + sb[1].size() != 0) begin bad++; $display("FAIL simul_missing_steps got=%0d pending want=0", sb[0].size() + sb[1].size()); end
    clr[1] = 1'b1; cyc(1); clr[1] = 1'b0; cyc(2);
    mcnt[1] = 0;
    total++; if (count[CW +: CW] !== '0) begin bad++; $display("FAIL clr_only_count1 got=%0d want=0", count[CW +: CW]); end
  endtask

  task automatic test_velocity;
`ifdef ENC_VELOCITY_EN
    int n, vs;
    n = 0;
    while (!vel_valid && n < 3000) begin @(negedge clk); n++; end
    total++; if (n >= 3000) begin bad++; $display("FAIL vel_first_window got=timeout want=vel_valid pulse"); end
    cyc(1);
    vs = vv_seen;
    cw(0); cw(0); cw(0);
    n = 0;
    while (!vel_valid && n < 3000) begin @(negedge clk); n++; end
    total++; if (vel[7:0] !== 8'd3) begin bad++; $display("FAIL vel0 got=%0d want=3", vel[7:0]); end
    total++; if (vel[15:8] !== 8'd0) begin bad++; $display("FAIL vel1 got=%0d want=0", vel[15:8]); end
    cyc(1);
    total++; if (vv_seen - vs != 1) begin bad++; $display("FAIL vel_valid_pulses got=%0d want=1", vv_seen - vs); end
`else
    cyc(20);
    total++; if (vel !== '0 || vel_valid !== 1'b0) begin bad++; $display("FAIL vel_tied got=%0h/%0b want=0/0", vel, vel_valid); end
    total++; if (vv_seen != 0) begin bad++; $display("FAIL vel_valid_seen got=%0d want=0", vv_seen); end
`endif
  endtask

  initial begin
    test_reset;
    test_cw;
    test_ccw_wrap;
    test_glitch;
    test_latency;
    test_reversal;
    test_back_to_back_clr;
    test_velocity;
    cyc(10);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
